// File: rtl/grf_mp_pkg.sv
// Shared constants and helpers for the multi-port general register file.
// Both grf_mp and grf_scoreboard import this package.
package grf_mp_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  // True when addr names the hard-wired zero register.
  function automatic logic addr_ignored(input logic [31:0] addr, input int zero_reg);
    return (zero_reg != 0) && (addr == 32'(REG_ZERO));
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-bit scoreboard for grf_mp: tracks registers whose producer has issued
// but not yet written back, and reports busy status per read port.
module grf_scoreboard
  import grf_mp_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NR*AW-1:0] radd,
  input  logic [NR-1:0]   rhit,
  input  logic [NW*AW-1:0] wadd,
  input  logic [NW-1:0]   wvld,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_add,
  input  logic            flush,
  output logic [NR-1:0]   rbusy
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pnext;

  // Flush beats everything; otherwise writebacks clear, then a new issue sets.
  always_comb begin
    pnext = pending;
    if (flush) begin
      pnext = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wvld[j]) pnext[wadd[j*AW +: AW]] = 1'b0;
      end
      if (iss_en && !addr_ignored(32'(iss_add), ZERO_REG)) pnext[iss_add] = 1'b1;
    end
    if (ZERO_REG != 0) pnext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pnext;
  end

  // A matching writeback this cycle resolves the hazard through the bypass.
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NR; i++) begin
      rbusy[i] = pending[radd[i*AW +: AW]] && !rhit[i];
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with write-through bypass on every read
// port, a pending-register scoreboard and a registered write-collision flag.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] radd,
  output logic [NR*DW-1:0] rdat,
  output logic [NR-1:0]    rbusy,
  input  logic [NW*AW-1:0] wadd,
  input  logic [NW-1:0]    wen,
  input  logic [NW*DW-1:0] wdat,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_add,
  input  logic             flush,
  output logic             wcoll
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] regs [DEPTH];
  logic [NW-1:0] wvld;
  logic [NR-1:0] rhit;
  logic          coll;

  always_comb begin
    wvld = '0;
    for (int j = 0; j < NW; j++) begin
      wvld[j] = wen[j] && !addr_ignored(32'(wadd[j*AW +: AW]), ZERO_REG);
    end
  end

  // Ascending port scan makes the highest matching write port win the bypass.
  always_comb begin
    rdat = '0;
    rhit = '0;
    for (int i = 0; i < NR; i++) begin
      rdat[i*DW +: DW] = regs[radd[i*AW +: AW]];
      for (int j = 0; j < NW; j++) begin
        if (wvld[j] && (wadd[j*AW +: AW] == radd[i*AW +: AW])) begin
          rhit[i]          = 1'b1;
          rdat[i*DW +: DW] = wdat[j*DW +: DW];
        end
      end
      if (addr_ignored(32'(radd[i*AW +: AW]), ZERO_REG)) rdat[i*DW +: DW] = '0;
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int j = 0; j < NW; j++) begin
      for (int k = j + 1; k < NW; k++) begin
        if (wvld[j] && wvld[k] && (wadd[j*AW +: AW] == wadd[k*AW +: AW])) coll = 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones when addresses collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
      wcoll <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wvld[j]) regs[wadd[j*AW +: AW]] <= wdat[j*DW +: DW];
      end
      wcoll <= coll;
    end
  end

  grf_scoreboard #(
    .AW       (AW),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .radd    (radd),
    .rhit    (rhit),
    .wadd    (wadd),
    .wvld    (wvld),
    .iss_en  (iss_en),
    .iss_add (iss_add),
    .flush   (flush),
    .rbusy   (rbusy)
  );

endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp (NR=2, NW=2); expectations are queued
// when stimulus is applied and popped when the outputs are sampled.
module tb_grf_mp;
  import grf_mp_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] radd;
  logic [NR*DW-1:0] rdat;
  logic [NR-1:0]    rbusy;
  logic [NW*AW-1:0] wadd;
  logic [NW-1:0]    wen;
  logic [NW*DW-1:0] wdat;
  logic             iss_en;
  logic [AW-1:0]    iss_add;
  logic             flush;
  logic             wcoll;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  grf_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .radd    (radd),
    .rdat    (rdat),
    .rbusy   (rbusy),
    .wadd    (wadd),
    .wen     (wen),
    .wdat    (wdat),
    .iss_en  (iss_en),
    .iss_add (iss_add),
    .flush   (flush),
    .wcoll   (wcoll)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic applyStimulus(input logic [1:0] w_en, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic ie, input logic [4:0] ia, input logic fl);
    @(negedge clk);
    wen     = w_en;
    wadd    = {wa1, wa0};
    wdat    = {wd1, wd0};
    radd    = {ra1, ra0};
    iss_en  = ie;
    iss_add = ia;
    flush   = fl;
    #2;
  endtask

  task automatic pushExp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    pushExp(tag, expv);
    checkOutput(obs);
  endtask

  initial begin
    rst = 1'b1; radd = '0; wadd = '0; wen = '0; wdat = '0;
    iss_en = 1'b0; iss_add = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("por_rdat",  64'(rdat),  64'h0);
    chk("por_rbusy", 64'(rbusy), 64'h0);
    chk("por_wcoll", 64'(wcoll), 64'h0);

    // Seed state that the mid-run reset must wipe.
    applyStimulus(2'b01, 5'd5, 32'hAAAA5555, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1, 5'd9, 1'b0);
    chk("seed_bypass", 64'(rdat[31:0]), 64'hAAAA5555);
    applyStimulus(2'b11, 5'd10, 32'h1, 5'd10, 32'h2, 5'd10, 5'd9, 1'b0, 5'd0, 1'b0);
    chk("coll_bypass", 64'(rdat[31:0]), 64'h2);
    chk("coll_busy9",  64'(rbusy), 64'h2);
    chk("coll_wcoll0", 64'(wcoll), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd9, 1'b0, 5'd0, 1'b0);
    chk("coll_stored", 64'(rdat[31:0]), 64'h2);
    chk("pre_rst_busy", 64'(rbusy), 64'h2);
    chk("pre_rst_wcoll", 64'(wcoll), 64'h1);

    // Asynchronous reset between clock edges.
    #1 rst = 1'b1;
    #1;
    chk("arst_rdat",  64'(rdat),  64'h0);
    chk("arst_rbusy", 64'(rbusy), 64'h0);
    chk("arst_wcoll", 64'(wcoll), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 5'd5, 5'd10, 1'b0, 5'd0, 1'b0);
    chk("w5_bypass", 64'(rdat[31:0]), 64'h12345678);
    chk("r10_reset", 64'(rdat[63:32]), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0);
    chk("r5_stored", 64'(rdat[31:0]), 64'h12345678);
    chk("r7_reset",  64'(rdat[63:32]), 64'h0);

    applyStimulus(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0, 1'b0);
    chk("w7_bypass", 64'(rdat[31:0]), 64'hDEADBEEF);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0, 1'b0);
    chk("r7_stored", 64'(rdat), {32'h12345678, 32'hDEADBEEF});

    // Register 0: writes, issue and collisions are all ignored.
    applyStimulus(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    chk("z_rdat_same",  64'(rdat),  64'h0);
    chk("z_rbusy_same", 64'(rbusy), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("z_rdat_after",  64'(rdat),  64'h0);
    chk("z_rbusy_after", 64'(rbusy), 64'h0);
    chk("z_no_wcoll",    64'(wcoll), 64'h0);

    // Scoreboard set / clear / set-wins.
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    chk("iss9_same", 64'(rbusy), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("iss9_busy", 64'(rbusy), 64'h1);
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("wb9_unbusy", 64'(rbusy), 64'h0);
    chk("wb9_bypass", 64'(rdat[31:0]), 64'h99);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("wb9_cleared", 64'(rbusy), 64'h0);
    chk("wb9_stored", 64'(rdat[31:0]), 64'h99);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h100, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    chk("setclr_same", 64'(rbusy), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd3, 1'b0);
    chk("set_wins", 64'(rbusy), 64'h1);
    chk("p1_stored", 64'(rdat[31:0]), 64'h100);

    // Flush discards pending bits and a same-cycle issue.
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd9, 1'b1, 5'd4, 1'b0);
    chk("pend3_9", 64'(rbusy), 64'h3);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 5'd6, 1'b1);
    chk("pre_flush", 64'(rbusy), 64'h1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
    chk("flush_3_4", 64'(rbusy), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd9, 1'b0, 5'd0, 1'b0);
    chk("flush_6_9", 64'(rbusy), 64'h0);

    // Collision: highest port wins, wcoll pulses for exactly one cycle.
    applyStimulus(2'b11, 5'd10, 32'h1, 5'd10, 32'h2, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("c2_bypass", 64'(rdat[31:0]), 64'h2);
    chk("c2_wcoll0", 64'(wcoll), 64'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("c2_stored", 64'(rdat[31:0]), 64'h2);
    chk("c2_wcoll1", 64'(wcoll), 64'h1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("c2_wcoll_drop", 64'(wcoll), 64'h0);

    // Two ports, distinct targets, including the return-address register.
    applyStimulus(2'b11, REG_RA[4:0], 32'h31, 5'd12, 32'h12, REG_RA[4:0], 5'd12, 1'b0, 5'd0, 1'b0);
    chk("dual_bypass", 64'(rdat), {32'h12, 32'h31});
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, REG_RA[4:0], 5'd12, 1'b0, 5'd0, 1'b0);
    chk("dual_stored", 64'(rdat), {32'h12, 32'h31});
    chk("dual_nocoll", 64'(wcoll), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor of the single-write, two-read GRF in the decode/writeback path.
- Adds a configurable number of read and write ports, same-cycle write-to-read bypass on every port, and a per-register pending scoreboard.
- The scoreboard lets the hazard unit stall consumers whose producer has not yet written back.
- Sits between the decode stage (read ports, issue) and the writeback stage(s) (write ports).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NR, 2, number of read ports (1..4).
- NW, 1, number of write ports (1..2).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- radd  in  NR*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdat  out  NR*DW  read data; port i occupies [i*DW +: DW].
- rbusy  out  NR  port i's register is pending and is not being written this cycle.
- wadd  in  NW*AW  write addresses.
- wen  in  NW  write enables.
- wdat  in  NW*DW  write data.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_add  in  AW  destination register of the issuing instruction.
- flush  in  1  synchronously clears all pending bits (pipeline flush).
- wcoll  out  1  registered flag: previous cycle had two enabled write ports targeting the same non-ignored address.

Behaviour:
- Storage: 2**AW x DW array, plus pending[2**AW-1:0]. With ZERO_REG=1, entry 0 is not implemented and pending[0] is tied to 0.
- Reset (async, rst=1): all registers = 0, all pending bits = 0, wcoll = 0. Combinational outputs follow from this: rdat = 0 for all ports, rbusy = 0.
- Writes:
  - At posedge clk, for each port j with wen[j]=1 and an address that is not ignored (wadd_j!=0, or ZERO_REG=0), reg[wadd_j] <= wdat_j.
  - If several ports hit the same address, the highest port index wins.
- Reads (combinational, 0-cycle latency), for each port i:
  - If ZERO_REG and radd_i==0: rdat_i = 0.
  - Else if any enabled write port j matches radd_i (and the address is not ignored): rdat_i = wdat of the highest such j (write-through bypass).
  - Else: rdat_i = reg[radd_i].
- rbusy_i = pending[radd_i] AND no enabled write port matches radd_i this cycle. It is 0 for an ignored register 0.
- Scoreboard update at posedge clk, evaluated in this order:
  1. flush=1: all pending <= 0. Any issue in the same cycle is discarded.
  2. Otherwise, each enabled write j clears pending[wadd_j].
  3. Then, if iss_en=1 and iss_add is not ignored, pending[iss_add] <= 1. Set wins over a clear of the same address in the same cycle (the new producer supersedes).
  - Issuing to an already-pending register keeps it pending. Single-bit tracking; in-order pipeline.
- wcoll <= 1 at the next posedge if, this cycle, two or more enabled write ports target the same non-ignored address; otherwise wcoll <= 0.
- Reset asserted mid-operation clears everything immediately, regardless of clk. The first posedge after rst deasserts behaves normally (writes and issues are accepted).
- Address arithmetic is unsigned; there is no out-of-range case, since depth = 2**AW exactly.
- NW=1 degenerates to single-write GRF behaviour plus the scoreboard; wcoll is then constantly 0.

Decomposition:
- Shared package/header (mips.vh):
  - Defaults DW/AW.
  - Register-number constants (REG_ZERO, REG_RA).
  - Port-slice helper macros for packing and unpacking flattened address/data buses.
- One natural sub-module, grf_scoreboard: pending-bit array, flush/clear/set priority logic and rbusy generation.
- Data array, bypass muxes and wcoll stay in grf_mp.

Test Plan:
1. Reset then read: assert rst mid-simulation, asynchronously between clock edges -> rdat=0 for all ports immediately, rbusy=0, wcoll=0. Then write wadd=5, wdat=0x12345678 -> next cycle, radd=5 reads 0x12345678.
2. Bypass: in a single cycle, wen[0]=1, wadd=7, wdat=0xDEADBEEF, radd0=7 -> rdat0=0xDEADBEEF in that same cycle (before the edge), and reg[7] holds it afterwards.
3. Zero register: write wadd=0, wdat=0xFFFFFFFF, and iss_en with iss_add=0 -> rdat for radd=0 stays 0; rbusy stays 0.
4. Scoreboard:
   - iss_en, iss_add=9 -> next cycle rbusy=1 for radd=9.
   - Then wen, wadd=9 -> rbusy=0 in that same cycle (bypass), and pending[9] is clear afterwards.
   - Simultaneous write to 9 and issue to 9 -> pending stays 1.
5. Flush: set pending on regs 3 and 4, then flush=1 together with iss_en, iss_add=6 -> next cycle rbusy=0 for radd 3, 4 and 6.
6. Write collision (NW=2): wen=2'b11, both ports wadd=10, wdat0=0x1, wdat1=0x2 -> same-cycle rdat for radd=10 = 0x2, reg[10]=0x2 afterwards, and wcoll=1 for exactly one cycle.
